// File: rtl/if_stage_pkg.sv
// Shared bus layouts for the instruction-fetch stage: pre-IF -> FS and FS -> ID bundles.
package if_stage_pkg;

  localparam int PS_TO_FS_BUS_WD = 41;
  localparam int FS_TO_DS_BUS_WD = 72;

  typedef struct packed {
    logic        s0_ex;
    logic        s0_refill_ex;
    logic [5:0]  ecode;
    logic        ps_ex;
    logic [31:0] pc;
  } ps_to_fs_t;

  typedef struct packed {
    logic        fs_ex;
    logic        refill_ex;
    logic [5:0]  ecode;
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

endpackage

// File: rtl/if_stage_if.sv
// Handshake and data signals between pre-IF, inst-SRAM response side, FS and ID.
interface if_stage_if;
  import if_stage_pkg::*;

  logic                       ps_to_fs_valid;
  logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus;
  logic                       ps_req_fire;
  logic                       fs_allowin;
  logic                       data_ok;
  logic [31:0]                inst_sram_rdata;
  logic                       ds_allowin;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       flush;
  logic                       br_cancel;
  logic                       fs_wrong_req;

  // The fetch stage itself.
  modport slave (
    input  ps_to_fs_valid, ps_to_fs_bus, ps_req_fire, data_ok, inst_sram_rdata,
           ds_allowin, flush, br_cancel,
    output fs_allowin, fs_to_ds_valid, fs_to_ds_bus, fs_wrong_req
  );

  // The surrounding pipeline and memory that drive the stage.
  modport master (
    output ps_to_fs_valid, ps_to_fs_bus, ps_req_fire, data_ok, inst_sram_rdata,
           ds_allowin, flush, br_cancel,
    input  fs_allowin, fs_to_ds_valid, fs_to_ds_bus, fs_wrong_req
  );

endinterface

// File: rtl/if_stage_fs_req_tracker.sv
// Counts inst-SRAM requests in flight and how many of their responses must be thrown away.
module fs_req_tracker #(
  parameter int MAX_OUTST = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic fire,
  input  logic data_ok,
  input  logic flush,
  input  logic cancel_waiting,
  output logic drop,
  output logic fs_wrong_req
);

  localparam int CW = $clog2(MAX_OUTST + 1);

  logic [CW-1:0] req_cnt;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] req_nxt;

  assign drop         = data_ok && (discard_cnt != '0);
  assign fs_wrong_req = (discard_cnt != '0);
  assign req_nxt      = req_cnt + CW'(fire) - CW'(data_ok);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_cnt     <= '0;
      discard_cnt <= '0;
    end else begin
      req_cnt <= req_nxt;
      // On flush every request still unanswered after this cycle belongs to dead entries.
      if (flush) discard_cnt <= req_nxt;
      else       discard_cnt <= discard_cnt - CW'(drop) + CW'(cancel_waiting);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(fire && !data_ok && req_cnt == CW'(MAX_OUTST)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    !(data_ok && req_cnt == '0));
  a_discard_bound: assert property (@(posedge clk) disable iff (!reset)
    discard_cnt <= req_cnt);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: pairs inst-SRAM responses with the FS entry, buffers on ID stall.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int MAX_OUTST = 2
) (
  input logic        clk,
  input logic        reset,
  if_stage_if.slave  fs_if
);

  ps_to_fs_t   ps;
  fs_to_ds_t   ds;

  logic        fs_valid;
  logic        fs_ex;
  logic        fs_refill;
  logic [5:0]  fs_ecode;
  logic [31:0] fs_pc;
  logic        buf_valid;
  logic [31:0] inst_buf;

  logic        drop;
  logic        resp_ok;
  logic        fs_ready_go;
  logic        accept;
  logic        waiting;
  logic        cancel_waiting;
  logic        hold_resp;

  assign ps = fs_if.ps_to_fs_bus;

  assign resp_ok     = fs_if.data_ok && !drop;
  assign fs_ready_go = fs_ex || buf_valid || resp_ok;
  assign fs_if.fs_allowin     = !fs_valid || (fs_ready_go && fs_if.ds_allowin);
  assign fs_if.fs_to_ds_valid = fs_valid && fs_ready_go && !fs_if.flush && !fs_if.br_cancel;

  assign accept    = fs_if.fs_allowin && fs_if.ps_to_fs_valid && !fs_if.flush;
  assign waiting   = fs_valid && !fs_ex && !buf_valid;
  assign hold_resp = waiting && resp_ok && !fs_if.ds_allowin;
  // A killed entry whose request is still out leaves one orphan response behind.
  assign cancel_waiting = fs_if.br_cancel && !fs_if.flush && waiting && !resp_ok;

  fs_req_tracker #(.MAX_OUTST(MAX_OUTST)) u_tracker (
    .clk            (clk),
    .reset          (reset),
    .fire           (fs_if.ps_req_fire),
    .data_ok        (fs_if.data_ok),
    .flush          (fs_if.flush),
    .cancel_waiting (cancel_waiting),
    .drop           (drop),
    .fs_wrong_req   (fs_if.fs_wrong_req)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fs_valid  <= 1'b0;
      fs_ex     <= 1'b0;
      fs_refill <= 1'b0;
      fs_ecode  <= '0;
      fs_pc     <= '0;
      buf_valid <= 1'b0;
      // NOTE: inst_buf is a single register, not a memory, so it is reset to keep the bus clean.
      inst_buf  <= '0;
    end else if (fs_if.flush) begin
      fs_valid  <= 1'b0;
      buf_valid <= 1'b0;
    end else if (accept) begin
      fs_valid  <= 1'b1;
      buf_valid <= 1'b0;
      // An s0 exception is an exception of this entry and never waits for memory.
      fs_ex     <= ps.ps_ex || ps.s0_ex;
      fs_refill <= ps.s0_refill_ex;
      fs_ecode  <= ps.ecode;
      fs_pc     <= ps.pc;
    end else if (fs_if.br_cancel || fs_if.fs_allowin) begin
      fs_valid  <= 1'b0;
      buf_valid <= 1'b0;
    end else if (hold_resp) begin
      buf_valid <= 1'b1;
      inst_buf  <= fs_if.inst_sram_rdata;
    end
  end

  assign ds.fs_ex     = fs_ex;
  assign ds.refill_ex = fs_refill;
  assign ds.ecode     = fs_ecode;
  assign ds.pc        = fs_pc;
  assign ds.inst      = (fs_valid && !fs_ex) ? (buf_valid ? inst_buf : fs_if.inst_sram_rdata) : '0;
  assign fs_if.fs_to_ds_bus = ds;

  a_resp_has_owner: assert property (@(posedge clk) disable iff (!reset)
    resp_ok |-> waiting);

endmodule
